gray_step_monitor: RTL and testbench

//  Consumes the Gray-coded output of the 8-bit free-running Gray counter.

---
 rtl/gray_step_monitor.sv | 144 ++++++++++++++
 tb/tb_gray_step_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// Registers an upstream Gray count, decodes it, and checks that each sample holds or steps by +1.
// Tracks lock after a run of +1 steps and keeps a saturating tally of illegal steps.
module gray_step_monitor #(
    parameter int WIDTH      = 8,
    parameter int ERR_W      = 8,
    parameter int LOCK_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             resync,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       dbg_state_o
);

    // Handshake: sample_en qualifies gray_in for one cycle; there is no back-pressure.
    // bin_valid marks the single cycle in which bin_out, step_err and locked reflect a new sample.

    localparam int RUN_W = (LOCK_STEPS < 2) ? 1 : $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_q;
    logic             v1_q;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_valid_q;
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] delta;
    logic             legal;
    logic             plus_one;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_new[i] = ^(g_q >> i);
        end
    end

    assign delta    = bin_new - prev_q;
    assign plus_one = (delta == WIDTH'(1));
    assign legal    = (delta == '0) || plus_one;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        step_err_d = 1'b0;
        bin_d      = v1_q ? bin_new : bin_q;
        prev_d     = v1_q ? bin_new : prev_q;
        if (resync) begin
            // A sample finishing in the resync cycle is shown but never judged.
            state_d = ST_EMPTY;
            run_d   = '0;
        end else if (v1_q) begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_ACQ;
                    run_d   = '0;
                end
                ST_ACQ: begin
                    if (!legal) begin
                        step_err_d = 1'b1;
                        run_d      = '0;
                    end else if (plus_one) begin
                        if (run_q == RUN_W'(LOCK_STEPS - 1)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!legal) begin
                        step_err_d = 1'b1;
                        state_d    = ST_ACQ;
                        run_d      = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end else if (step_err_d && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            g_q         <= '0;
            v1_q        <= 1'b0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            prev_q      <= '0;
            run_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= sample_en ? gray_in : g_q;
            v1_q        <= sample_en;
            bin_q       <= bin_d;
            bin_valid_q <= v1_q;
            step_err_q  <= step_err_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign bin_out     = bin_q;
    assign bin_valid   = bin_valid_q;
    assign step_err    = step_err_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_count   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios then random traffic, checked each cycle
// against a sample-level reference model; a second instance with a 2-bit error tally.
module tb_gray_step_monitor;

    localparam int W  = 8;
    localparam int LS = 4;

    logic       clk;
    logic       rst_n;
    logic       sample_en;
    logic [7:0] gray_in;
    logic       resync;
    logic       clr_err;

    logic [7:0] bin_out_a,  bin_out_b;
    logic       bin_valid_a, bin_valid_b;
    logic       step_err_a, step_err_b;
    logic       locked_a,   locked_b;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic [1:0] dbg_a, dbg_b;

    int n_checks;
    int n_errors;

    // Reference model state
    logic       cur_en, cur_rs, cur_clr;
    logic [7:0] cur_g;
    logic       pend_v;
    logic [7:0] pend_g;
    logic       m_seeded, m_locked, m_bv, m_se;
    int         m_run;
    int         m_prev, m_bin;
    int         m_err8, m_err2;
    int         cnt;

    gray_step_monitor #(.WIDTH(8), .ERR_W(8), .LOCK_STEPS(LS)) dut_a (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .gray_in(gray_in),
        .resync(resync), .clr_err(clr_err), .bin_out(bin_out_a), .bin_valid(bin_valid_a),
        .step_err(step_err_a), .locked(locked_a), .err_count(err_a), .dbg_state_o(dbg_a)
    );

    gray_step_monitor #(.WIDTH(8), .ERR_W(2), .LOCK_STEPS(LS)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .gray_in(gray_in),
        .resync(resync), .clr_err(clr_err), .bin_out(bin_out_b), .bin_valid(bin_valid_b),
        .step_err(step_err_b), .locked(locked_b), .err_count(err_b), .dbg_state_o(dbg_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_gray(input int b);
        logic [7:0] v;
        v = 8'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [7:0] g);
        int b;
        b = 0;
        for (int i = 0; i < W; i++) b = b ^ int'(g >> i);
        return b & 8'hFF;
    endfunction

    task automatic model_reset();
        cur_en = 0; cur_rs = 0; cur_clr = 0; cur_g = 0;
        pend_v = 0; pend_g = 0;
        m_seeded = 0; m_locked = 0; m_bv = 0; m_se = 0;
        m_run = 0; m_prev = 0; m_bin = 0; m_err8 = 0; m_err2 = 0;
    endtask

    // One clock edge of the reference: the sample presented two cycles ago completes.
    task automatic model_step();
        int d;
        m_bv = 0;
        m_se = 0;
        if (pend_v) begin
            m_bin = from_gray(pend_g);
            m_bv  = 1;
            if (!cur_rs) begin
                if (!m_seeded) begin
                    m_seeded = 1;
                    m_run    = 0;
                end else begin
                    d = (m_bin - m_prev + 256) % 256;
                    if (d > 1) begin
                        m_se     = 1;
                        m_run    = 0;
                        m_locked = 0;
                    end else if (d == 1 && !m_locked) begin
                        m_run++;
                        if (m_run >= LS) begin
                            m_locked = 1;
                            m_run    = 0;
                        end
                    end
                end
            end
            m_prev = m_bin;
        end
        if (cur_rs) begin
            m_seeded = 0;
            m_run    = 0;
            m_locked = 0;
        end
        if (cur_clr) begin
            m_err8 = 0;
            m_err2 = 0;
        end else if (m_se) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3)   m_err2++;
        end
        pend_v = cur_en;
        pend_g = cur_g;
    endtask

    task automatic check_outputs();
        chk("bin_out",   bin_out_a,   m_bin);
        chk("bin_valid", bin_valid_a, m_bv);
        chk("step_err",  step_err_a,  m_se);
        chk("locked",    locked_a,    m_locked);
        chk("err_count", err_a,       m_err8);
        chk("err_sat2",  err_b,       m_err2);
        chk("step_err2", step_err_b,  m_se);
    endtask

    task automatic cycle(input logic en, input logic [7:0] g, input logic rs, input logic clr);
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
        sample_en = en; gray_in = g; resync = rs; clr_err = clr;
        cur_en = en; cur_g = g; cur_rs = rs; cur_clr = clr;
    endtask

    task automatic feed_bin(input int b);
        cycle(1'b1, to_gray(b), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_resync();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Asynchronous reset landing mid-cycle, with outputs checked before any clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        sample_en = 0; gray_in = 0; resync = 0; clr_err = 0;
        #1;
        chk("rst_bin_out",   bin_out_a,   0);
        chk("rst_bin_valid", bin_valid_a, 0);
        chk("rst_step_err",  step_err_a,  0);
        chk("rst_locked",    locked_a,    0);
        chk("rst_err_count", err_a,       0);
        chk("rst_err_sat2",  err_b,       0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        sample_en = 0; gray_in = 0; resync = 0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // T1: reset mid-stream, then a lone Gray 0
        for (int b = 0; b < 8; b++) feed_bin(b);
        async_reset();
        feed_bin(0);
        idle(4);

        // T2: full sweep, one sample per cycle
        for (int b = 0; b < 256; b++) feed_bin(b);
        idle(3);

        // T3: wrap through all-ones
        do_resync();
        for (int b = 16'hFD; b < 16'hFD + 12; b++) feed_bin(b % 256);
        idle(3);

        // T4: fault while locked, then relock
        do_resync();
        for (int b = 8'h0C; b <= 8'h10; b++) feed_bin(b);
        feed_bin(8'h13);
        for (int b = 8'h14; b <= 8'h18; b++) feed_bin(b);
        idle(3);

        // T5: upstream reset with and without resync
        do_resync();
        for (int b = 8'h30; b <= 8'h37; b++) feed_bin(b);
        idle(1);
        do_resync();
        for (int b = 0; b <= 6; b++) feed_bin(b);
        idle(2);
        feed_bin(0);
        idle(3);

        // T6: saturation of the 2-bit tally, then clear coinciding with an error
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        do_resync();
        feed_bin(0);
        for (int k = 0; k < 5; k++) feed_bin((k % 2 == 0) ? 8'h80 : 8'h00);
        idle(2);
        feed_bin(0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);

        // Random traffic: mostly legal steps with gaps, holds, jumps, resyncs and clears
        cnt = 0;
        for (int t = 0; t < 3000; t++) begin
            int r;
            logic en, rs, clr;
            en  = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 2);
            if (en) begin
                r = $urandom_range(0, 99);
                if (r < 65)      cnt = (cnt + 1) % 256;
                else if (r < 90) cnt = cnt;
                else             cnt = $urandom_range(0, 255);
            end
            cycle(en, to_gray(cnt), rs, clr);
            if (t == 1500) begin
                async_reset();
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
